// File: rtl/swap_rf_pkg.sv
// Shared definitions for the swap register file and the swapper controller:
// FSM encoding of the swap engine and default geometry constants.
package swap_rf_pkg;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_RD_PORTS   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XCHG   = 2'd1,
        COMMIT = 2'd2
    } swap_state_t;

endpackage

// File: rtl/mem_array_mr.sv
// Storage array with one synchronous write port, RD_PORTS asynchronous host read
// ports and two internal asynchronous reads feeding the swap engine.
module mem_array_mr #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int RD_PORTS   = 2
) (
    input  logic                           clk,
    input  logic                           write_en,
    input  logic [ADDR_WIDTH-1:0]          address_w,
    input  logic [DATA_WIDTH-1:0]          data_w,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] address_r,
    output logic [RD_PORTS*DATA_WIDTH-1:0] data_r,
    input  logic [ADDR_WIDTH-1:0]          address_a,
    input  logic [ADDR_WIDTH-1:0]          address_b,
    output logic [DATA_WIDTH-1:0]          data_a,
    output logic [DATA_WIDTH-1:0]          data_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Array is deliberately left without reset so it maps onto plain storage.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[address_w] <= data_w;
        end
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        assign data_r[i*DATA_WIDTH +: DATA_WIDTH] = mem[address_r[i*ADDR_WIDTH +: ADDR_WIDTH]];
    end

    assign data_a = mem[address_a];
    assign data_b = mem[address_b];

endmodule

// File: rtl/swap_reg_file.sv
// Register file with async multi-port reads, a host write port and a built-in
// engine that exchanges two locations over a req/busy/done handshake.
module swap_reg_file
    import swap_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_PORTS   = DEF_RD_PORTS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           write_en,
    input  logic [ADDR_WIDTH-1:0]          address_w,
    input  logic [DATA_WIDTH-1:0]          data_w,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] address_r,
    output logic [RD_PORTS*DATA_WIDTH-1:0] data_r,
    input  logic                           swap_req,
    input  logic [ADDR_WIDTH-1:0]          swap_addr_a,
    input  logic [ADDR_WIDTH-1:0]          swap_addr_b,
    output logic                           swap_busy,
    output logic                           swap_done,
    output logic                           wr_dropped
);

    swap_state_t           state;
    swap_state_t           next_state;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] tmp;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    mem_array_mr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_PORTS   (RD_PORTS)
    ) u_mem (
        .clk       (clk),
        .write_en  (mem_we),
        .address_w (mem_addr),
        .data_w    (mem_data),
        .address_r (address_r),
        .data_r    (data_r),
        .address_a (addr_a),
        .address_b (addr_b),
        .data_a    (rd_a),
        .data_b    (rd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_a     <= '0;
            addr_b     <= '0;
            tmp        <= '0;
            swap_done  <= 1'b0;
            wr_dropped <= 1'b0;
        end else begin
            state      <= next_state;
            swap_done  <= (state == COMMIT);
            wr_dropped <= write_en && (state != IDLE);
            if (state == IDLE && swap_req) begin
                addr_a <= swap_addr_a;
                addr_b <= swap_addr_b;
            end
            if (state == XCHG) begin
                tmp <= rd_a;
            end
        end
    end

    // The single array write port is owned by the host in IDLE and by the swap engine otherwise.
    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        case (state)
            IDLE: begin
                if (write_en) begin
                    mem_we   = 1'b1;
                    mem_addr = address_w;
                    mem_data = data_w;
                end
                if (swap_req) begin
                    next_state = XCHG;
                end
            end
            XCHG: begin
                mem_we     = 1'b1;
                mem_addr   = addr_a;
                mem_data   = rd_b;
                next_state = COMMIT;
            end
            COMMIT: begin
                mem_we     = 1'b1;
                mem_addr   = addr_b;
                mem_data   = tmp;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign swap_busy = (state != IDLE);

endmodule

// File: tb/tb_swap_reg_file.sv
// Scoreboard bench for swap_reg_file: a default instance and a wide one
// (RD_PORTS=4, DATA_WIDTH=32) driven in lockstep against a reference array.
module tb_swap_reg_file;

    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int RP  = 2;
    localparam int WDW = 32;
    localparam int WRP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               write_en = 1'b0;
    logic [AW-1:0]      address_w = '0;
    logic [DW-1:0]      data_w = '0;
    logic [WDW-1:0]     data_w_wide = '0;
    logic [RP*AW-1:0]   address_r = '0;
    logic [RP*DW-1:0]   data_r;
    logic [WRP*AW-1:0]  address_r_wide = '0;
    logic [WRP*WDW-1:0] data_r_wide;
    logic               swap_req = 1'b0;
    logic [AW-1:0]      swap_addr_a = '0;
    logic [AW-1:0]      swap_addr_b = '0;
    logic               swap_busy, swap_done, wr_dropped;
    logic               swap_busy_wide, swap_done_wide, wr_dropped_wide;

    swap_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_PORTS(RP)) dut (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .address_w(address_w),
        .data_w(data_w), .address_r(address_r), .data_r(data_r), .swap_req(swap_req),
        .swap_addr_a(swap_addr_a), .swap_addr_b(swap_addr_b), .swap_busy(swap_busy),
        .swap_done(swap_done), .wr_dropped(wr_dropped)
    );

    swap_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(WDW), .RD_PORTS(WRP)) dut_wide (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .address_w(address_w),
        .data_w(data_w_wide), .address_r(address_r_wide), .data_r(data_r_wide),
        .swap_req(swap_req), .swap_addr_a(swap_addr_a), .swap_addr_b(swap_addr_b),
        .swap_busy(swap_busy_wide), .swap_done(swap_done_wide), .wr_dropped(wr_dropped_wide)
    );

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0]  ref_mem  [2**AW];
    logic [WDW-1:0] ref_wide [2**AW];

    typedef struct {
        bit             wide;
        logic [AW-1:0]  addr;
        logic [WDW-1:0] data;
        string          tag;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [WDW-1:0] widen(input logic [DW-1:0] d);
        return {d, ~d, 8'h5A, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic req, input logic [AW-1:0] a, input logic [AW-1:0] b);
        write_en    = we;
        address_w   = wa;
        data_w      = wd;
        data_w_wide = widen(wd);
        swap_req    = req;
        swap_addr_a = a;
        swap_addr_b = b;
    endtask

    task automatic hostWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        applyStimulus(1'b1, a, d, 1'b0, '0, '0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        ref_mem[a]  = d;
        ref_wide[a] = widen(d);
    endtask

    task automatic expectMem(input string tag, input logic [AW-1:0] a);
        exp_q.push_back('{wide: 1'b0, addr: a, data: {24'h0, ref_mem[a]}, tag: tag});
        exp_q.push_back('{wide: 1'b1, addr: a, data: ref_wide[a], tag: {tag, "_wide"}});
    endtask

    // Pops every queued expectation and compares it through a rotating read port.
    task automatic drainScoreboard();
        exp_t e;
        int   idx;
        int   p;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!e.wide) begin
                p = idx % RP;
                address_r[p*AW +: AW] = e.addr;
                #1;
                checkOutput(e.tag, {24'h0, data_r[p*DW +: DW]}, e.data);
            end else begin
                p = idx % WRP;
                address_r_wide[p*AW +: AW] = e.addr;
                #1;
                checkOutput(e.tag, data_r_wide[p*WDW +: WDW], e.data);
            end
            idx++;
            if (idx % 4 == 0) tick();
        end
    endtask

    task automatic modelSwap(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [DW-1:0]  t;
        logic [WDW-1:0] tw;
        t  = ref_mem[a];  ref_mem[a]  = ref_mem[b];  ref_mem[b]  = t;
        tw = ref_wide[a]; ref_wide[a] = ref_wide[b]; ref_wide[b] = tw;
    endtask

    // Full handshake of one swap, optionally with a host write in the request cycle.
    task automatic runSwap(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        applyStimulus(we, wa, wd, 1'b1, a, b);
        if (we) begin
            ref_mem[wa]  = wd;
            ref_wide[wa] = widen(wd);
        end
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput({tag, "_busy_e0"}, {31'h0, swap_busy}, 32'd1);
        checkOutput({tag, "_done_e0"}, {31'h0, swap_done}, 32'd0);
        tick();
        checkOutput({tag, "_busy_e1"}, {31'h0, swap_busy_wide}, 32'd1);
        address_r[0 +: AW] = a;
        address_r_wide[3*AW +: AW] = a;
        #1;
        checkOutput({tag, "_mid_a"}, {24'h0, data_r[0 +: DW]}, {24'h0, ref_mem[b]});
        checkOutput({tag, "_mid_a_wide"}, data_r_wide[3*WDW +: WDW], ref_wide[b]);
        tick();
        checkOutput({tag, "_busy_e2"}, {31'h0, swap_busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'h0, swap_done}, 32'd1);
        checkOutput({tag, "_done_wide"}, {31'h0, swap_done_wide}, 32'd1);
        tick();
        checkOutput({tag, "_done_clear"}, {31'h0, swap_done}, 32'd0);
        modelSwap(a, b);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dones;

        // Test 1: reset state, then asynchronous assertion mid-swap.
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) tick();
        checkOutput("rst_busy", {31'h0, swap_busy}, 32'd0);
        checkOutput("rst_done", {31'h0, swap_done}, 32'd0);
        checkOutput("rst_dropped", {31'h0, wr_dropped}, 32'd0);
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 7'd1, 7'd2);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("pre_async_busy", {31'h0, swap_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_busy", {31'h0, swap_busy}, 32'd0);
        checkOutput("async_busy_wide", {31'h0, swap_busy_wide}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 2: basic write/read and swap.
        hostWrite(7'd3, 8'h11);
        hostWrite(7'd9, 8'h22);
        expectMem("t2_rd3", 7'd3);
        expectMem("t2_rd9", 7'd9);
        drainScoreboard();
        runSwap("t2_swap", 7'd3, 7'd9, 1'b0, '0, '0);
        expectMem("t2_post3", 7'd3);
        expectMem("t2_post9", 7'd9);
        drainScoreboard();

        // Test 3: swap of a location with itself.
        hostWrite(7'd5, 8'hA5);
        runSwap("t3_self", 7'd5, 7'd5, 1'b0, '0, '0);
        expectMem("t3_mem5", 7'd5);
        drainScoreboard();

        // Test 4: host write and second request while busy.
        hostWrite(7'd7, 8'h77);
        applyStimulus(1'b0, '0, '0, 1'b1, 7'd3, 7'd9);
        tick();
        applyStimulus(1'b1, 7'd7, 8'hFF, 1'b1, 7'd3, 7'd9);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("t4_dropped", {31'h0, wr_dropped}, 32'd1);
        checkOutput("t4_dropped_wide", {31'h0, wr_dropped_wide}, 32'd1);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (swap_done) dones++;
            if (i == 0) checkOutput("t4_dropped_clear", {31'h0, wr_dropped}, 32'd0);
        end
        checkOutput("t4_done_count", dones, 32'd1);
        modelSwap(7'd3, 7'd9);
        expectMem("t4_mem7", 7'd7);
        expectMem("t4_mem3", 7'd3);
        expectMem("t4_mem9", 7'd9);
        drainScoreboard();

        // Test 5: write in the same cycle as the swap request.
        runSwap("t5_swap", 7'd3, 7'd9, 1'b1, 7'd3, 8'h44);
        expectMem("t5_mem9", 7'd9);
        expectMem("t5_mem3", 7'd3);
        drainScoreboard();

        // Test 6: reset after the exchange edge leaves a duplicated value.
        hostWrite(7'd3, 8'h11);
        hostWrite(7'd9, 8'h22);
        applyStimulus(1'b0, '0, '0, 1'b1, 7'd3, 7'd9);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("t6_busy", {31'h0, swap_busy}, 32'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (swap_done || swap_done_wide) dones++;
        end
        checkOutput("t6_no_done", dones, 32'd0);
        ref_mem[3]  = ref_mem[9];
        ref_wide[3] = ref_wide[9];
        expectMem("t6_mem3", 7'd3);
        expectMem("t6_mem9", 7'd9);
        drainScoreboard();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
